axis_duty_sequencer: RTL

Upstream stage of `axis_pwm_generator`: generates a paced AXI4-Stream of duty-cycle words that drive the PWM generator's stream input. Supports constant, sawtooth and triangle duty profiles at a programmable beat rate. Configuration comes from the AXI4-Lite register block as static ports. `TLAST` marks the end of each profile period, so downstream logic can count periods.

---
 rtl/axis_pwm_pkg.sv | 19 +
 rtl/pwm_tick_prescaler.sv | 28 ++
 rtl/axis_duty_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axis_pwm_pkg.sv
// Shared definitions for the PWM stream path: mode encodings, sequencer
// state type and the stall counter ceiling.
package axis_pwm_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SAW  = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Free-running 0..prescale counter that emits a one-cycle tick on the
// terminal count; shared by the duty sequencer and the PWM generator.
module pwm_tick_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;

  assign tick = enable && !clear && (count_q == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/axis_duty_sequencer.sv
// Paced AXI4-Stream source of duty words following a hold, sawtooth or
// triangle profile; TLAST marks the end of each profile period.
module axis_duty_sequencer
  import axis_pwm_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cfg_enable,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_WIDTH-1:0]     cfg_min,
  input  logic [DATA_WIDTH-1:0]     cfg_max,
  input  logic [DATA_WIDTH-1:0]     cfg_step,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [15:0]               stall_count,
  output seq_state_t                dbg_state
);

  // Stream handshake: a beat transfers on a rising ACLK edge where tvalid and
  // tready are both high; tvalid/tdata/tlast are registered, never depend on
  // tready combinationally, and stay frozen while tvalid is high until transfer.

  logic                      enable_q;
  logic                      enable_rise;
  logic                      eff_hold;
  seq_state_t                state_q, state_d;
  logic [1:0]                mode_q;
  logic [DATA_WIDTH-1:0]     min_q, max_q, step_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [DATA_WIDTH-1:0]     cur_q, cur_d;
  logic                      wrap_q, wrap_d;
  logic                      run;
  logic                      tick;
  logic                      out_free;
  logic                      advance;
  logic                      beat_last;
  logic [DATA_WIDTH:0]       sum;
  logic [DATA_WIDTH:0]       diff;

  assign enable_rise = cfg_enable && !enable_q;
  assign eff_hold    = (cfg_mode == MODE_HOLD) || (cfg_mode == MODE_RSVD) ||
                       (cfg_step == '0) || (cfg_min >= cfg_max);
  assign run         = cfg_enable && (state_q != ST_IDLE);
  assign out_free    = !m_axis_tvalid || m_axis_tready;
  assign advance     = tick && out_free;
  assign sum         = {1'b0, cur_q} + {1'b0, step_q};
  assign diff        = {1'b0, cur_q} - {1'b0, step_q};
  assign dbg_state   = state_q;

  pwm_tick_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (ACLK),
    .rst      (ARESET),
    .enable   (run),
    .clear    (!run),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      enable_q   <= 1'b0;
      mode_q     <= MODE_HOLD;
      min_q      <= '0;
      max_q      <= '0;
      step_q     <= '0;
      prescale_q <= '0;
    end else begin
      enable_q <= cfg_enable;
      if (enable_rise) begin
        mode_q     <= cfg_mode;
        min_q      <= cfg_min;
        max_q      <= cfg_max;
        step_q     <= cfg_step;
        prescale_q <= cfg_prescale;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      wrap_q  <= wrap_d;
    end
  end

  // wrap_q flags that the next triangle beat is the cfg_min closing a DOWN
  // phase, so the very first beat of a run carries tlast=0.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    wrap_d    = wrap_q;
    beat_last = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_rise) begin
            state_d = eff_hold ? ST_HOLD : ST_UP;
            cur_d   = cfg_min;
            wrap_d  = 1'b0;
          end
        end
        ST_HOLD: begin
          beat_last = 1'b1;
        end
        ST_UP: begin
          if (mode_q == MODE_SAW) begin
            if (sum > {1'b0, max_q}) begin
              beat_last = 1'b1;
              if (advance) cur_d = min_q;
            end else if (advance) begin
              cur_d = sum[DATA_WIDTH-1:0];
            end
          end else begin
            beat_last = wrap_q;
            if (advance) begin
              wrap_d = 1'b0;
              if (sum >= {1'b0, max_q}) begin
                cur_d   = max_q;
                state_d = ST_DOWN;
              end else begin
                cur_d = sum[DATA_WIDTH-1:0];
              end
            end
          end
        end
        ST_DOWN: begin
          if (advance) begin
            if ($signed(diff) <= $signed({1'b0, min_q})) begin
              cur_d   = min_q;
              state_d = ST_UP;
              wrap_d  = 1'b1;
            end else begin
              cur_d = diff[DATA_WIDTH-1:0];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (advance) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= cur_q;
      m_axis_tlast  <= beat_last;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // A tick that finds an unaccepted beat is dropped and counted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stall_count <= '0;
    end else if (tick && !out_free && (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
